sram_responder: RTL and testbench

Synthesizable device-side model of the external 16-bit asynchronous SRAM: it decodes the active-low chip controls (CSX/OEX/WEX), stores written words in an internal array and returns read data on the bus after a programmable latency. It sits opposite the SRAM controller, on the pin side. It is used in on-FPGA loopback builds, where a second core stands in for the SRAM chip, and in simulation benches. Tri-state pin handling stays in the top level, so this block exposes split data-in, data-out and output-enable signals.

---
 rtl/sram_pkg.sv | 44 ++++
 rtl/sram_responder_mem.sv | 36 +++
 rtl/sram_responder.sv | 156 +++++++++++++++
 tb/tb_sram_responder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_pkg
// Brief    : Shared states, pin decode and limits for the SRAM responder.
// Revision : 1.0 - initial release
// ============================================================================
package sram_pkg;

   localparam int c_rd_lat_min = 1;
   localparam int c_rd_lat_max = 4;
   localparam int c_cnt_w      = 2;
   localparam int c_stat_w     = 16;

   localparam logic [c_stat_w-1:0] c_stat_max = '1;

   // Every chip control pin is asserted low
   localparam logic c_ctl_on = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_READ_WAIT  = 2'd1,
      ST_READ_DRIVE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OP_IDLE  = 2'd0,
      OP_WRITE = 2'd1,
      OP_READ  = 2'd2
   } op_t;

   // Write wins over read when WEX and OEX are both asserted
   function automatic op_t decode_op(input logic csx, input logic oex, input logic wex);
      op_t op;
      op = OP_IDLE;
      if (csx == c_ctl_on && wex == c_ctl_on) begin
         op = OP_WRITE;
      end else if (csx == c_ctl_on && oex == c_ctl_on) begin
         op = OP_READ;
      end
      return op;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sram_responder_mem.sv
`default_nettype none
// ============================================================================
// Module   : sram_responder_mem
// Brief    : Single-port synchronous word array, write-first, no reset.
// Revision : 1.0 - initial release
// ============================================================================
module sram_responder_mem #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH_LOG2 = 12
) (
   input  logic                  CLK,
   input  logic                  i_en,
   input  logic                  i_we,
   input  logic [DEPTH_LOG2-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0] i_din,
   output logic [DATA_WIDTH-1:0] o_dout
);

   logic [DATA_WIDTH-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];
   logic [DATA_WIDTH-1:0] r_dout;

   always_ff @(posedge CLK) begin
      if (i_en) begin
         if (i_we) begin
            r_mem[i_addr] <= i_din;
            r_dout        <= i_din;
         end else begin
            r_dout <= r_mem[i_addr];
         end
      end
   end

   assign o_dout = r_dout;

endmodule
`default_nettype wire

// File: rtl/sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : sram_responder
// Brief    : Pin-side model of a 16-bit async SRAM with programmable read
//            latency, saturating activity counters and a sticky conflict flag.
// Revision : 1.0 - initial release
// ============================================================================
module sram_responder
   import sram_pkg::*;
#(
   parameter int ADDR_WIDTH   = 18,
   parameter int DATA_WIDTH   = 16,
   parameter int DEPTH_LOG2   = 12,
   parameter int READ_LATENCY = 2
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  CSX,
   input  logic                  OEX,
   input  logic                  WEX,
   input  logic [ADDR_WIDTH-1:0] ADDRESS,
   input  logic [DATA_WIDTH-1:0] DATA_IN,
   output logic [DATA_WIDTH-1:0] DATA_OUT,
   output logic                  DATA_OE,
   output logic [15:0]           READ_COUNT,
   output logic [15:0]           WRITE_COUNT,
   output logic                  CONFLICT
);

   if (READ_LATENCY < c_rd_lat_min || READ_LATENCY > c_rd_lat_max) begin : g_bad_latency
      $error("sram_responder: READ_LATENCY outside 1..4");
   end

   localparam logic [c_cnt_w-1:0] c_cnt_reload = c_cnt_w'(READ_LATENCY - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_raddr;
   logic [c_cnt_w-1:0]    r_cnt;
   logic [c_cnt_w-1:0]    w_cnt_nxt;
   logic [c_stat_w-1:0]   r_rd_cnt;
   logic [c_stat_w-1:0]   r_wr_cnt;
   logic                  r_conflict;
   logic                  r_out_vld;

   op_t                   w_op;
   logic                  w_wr;
   logic                  w_rd;
   logic                  w_same;
   logic                  w_latch;
   logic                  w_mem_re;
   logic                  w_rd_done;
   logic [DATA_WIDTH-1:0] w_mem_q;

   assign w_op   = decode_op(CSX, OEX, WEX);
   assign w_wr   = (w_op == OP_WRITE);
   assign w_rd   = (w_op == OP_READ);
   assign w_same = (ADDRESS == r_raddr);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_latch     = 1'b0;
      w_mem_re    = 1'b0;
      w_rd_done   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_rd) begin
               w_state_nxt = ST_READ_WAIT;
               w_latch     = 1'b1;
               w_cnt_nxt   = c_cnt_reload;
            end
         end
         ST_READ_WAIT: begin
            if (!w_rd) begin
               w_state_nxt = ST_IDLE;
            end else if (!w_same) begin
               w_latch   = 1'b1;
               w_cnt_nxt = c_cnt_reload;
            end else if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else begin
               w_state_nxt = ST_READ_DRIVE;
               w_mem_re    = 1'b1;
               w_rd_done   = 1'b1;
            end
         end
         ST_READ_DRIVE: begin
            if (!w_rd) begin
               w_state_nxt = ST_IDLE;
            end else if (w_same) begin
               w_mem_re = 1'b1;
            end else begin
               w_state_nxt = ST_READ_WAIT;
               w_latch     = 1'b1;
               w_cnt_nxt   = c_cnt_reload;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state    <= ST_IDLE;
         r_raddr    <= '0;
         r_cnt      <= '0;
         r_rd_cnt   <= '0;
         r_wr_cnt   <= '0;
         r_conflict <= 1'b0;
         r_out_vld  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_latch) begin
            r_raddr <= ADDRESS;
         end
         if (w_rd_done && r_rd_cnt != c_stat_max) begin
            r_rd_cnt <= r_rd_cnt + 1'b1;
         end
         if (w_wr && r_wr_cnt != c_stat_max) begin
            r_wr_cnt <= r_wr_cnt + 1'b1;
         end
         if (w_wr && OEX == c_ctl_on) begin
            r_conflict <= 1'b1;
         end
         if (w_mem_re) begin
            r_out_vld <= 1'b1;
         end
      end
   end

   // Reads only load while ADDRESS matches r_raddr, so one index serves both ports
   sram_responder_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_mem (
      .CLK    (CLK),
      .i_en   (w_wr | w_mem_re),
      .i_we   (w_wr),
      .i_addr (ADDRESS[DEPTH_LOG2-1:0]),
      .i_din  (DATA_IN),
      .o_dout (w_mem_q)
   );

   // The array output register has no reset; mask it until the first real load
   assign DATA_OUT    = r_out_vld ? w_mem_q : '0;
   assign DATA_OE     = (r_state == ST_READ_DRIVE) & w_rd & w_same;
   assign READ_COUNT  = r_rd_cnt;
   assign WRITE_COUNT = r_wr_cnt;
   assign CONFLICT    = r_conflict;

endmodule
`default_nettype wire

// File: tb/tb_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_responder
// Brief    : Directed self-checking bench for sram_responder (READ_LATENCY=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_responder;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        CSX;
   logic        OEX;
   logic        WEX;
   logic [17:0] ADDRESS;
   logic [15:0] DATA_IN;
   logic [15:0] DATA_OUT;
   logic        DATA_OE;
   logic [15:0] READ_COUNT;
   logic [15:0] WRITE_COUNT;
   logic        CONFLICT;

   int total = 0;
   int bad   = 0;

   sram_responder #(
      .ADDR_WIDTH   (18),
      .DATA_WIDTH   (16),
      .DEPTH_LOG2   (12),
      .READ_LATENCY (2)
   ) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .CSX         (CSX),
      .OEX         (OEX),
      .WEX         (WEX),
      .ADDRESS     (ADDRESS),
      .DATA_IN     (DATA_IN),
      .DATA_OUT    (DATA_OUT),
      .DATA_OE     (DATA_OE),
      .READ_COUNT  (READ_COUNT),
      .WRITE_COUNT (WRITE_COUNT),
      .CONFLICT    (CONFLICT)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      RST_N = 1'b0; CSX = 1'b0; OEX = 1'b0; WEX = 1'b1;
      ADDRESS = 18'h00005; DATA_IN = 16'h0000;
      tick(); tick();
      chk("rst_oe",   32'(DATA_OE),     32'h0);
      chk("rst_dout", 32'(DATA_OUT),    32'h0);
      chk("rst_rc",   32'(READ_COUNT),  32'h0);
      chk("rst_wc",   32'(WRITE_COUNT), 32'h0);
      chk("rst_conf", 32'(CONFLICT),    32'h0);

      CSX = 1'b1; #2 RST_N = 1'b1;
      tick(); tick();
      chk("rel_rc", 32'(READ_COUNT),  32'h0);
      chk("rel_wc", 32'(WRITE_COUNT), 32'h0);
      chk("rel_oe", 32'(DATA_OE),     32'h0);

      // two back-to-back writes
      CSX = 1'b0; WEX = 1'b0; OEX = 1'b1; ADDRESS = 18'h00006; DATA_IN = 16'h1234;
      tick();
      ADDRESS = 18'h00005; DATA_IN = 16'hBEEF;
      tick();
      chk("wr_wc", 32'(WRITE_COUNT), 32'h2);

      // read 0x5, latency 2
      WEX = 1'b1; OEX = 1'b0;
      #1 chk("rd_oe_pre", 32'(DATA_OE), 32'h0);
      tick(); chk("rd_oe_e0", 32'(DATA_OE), 32'h0);
      tick(); chk("rd_oe_e1", 32'(DATA_OE), 32'h0);
      tick();
      chk("rd_oe_e2",   32'(DATA_OE),    32'h1);
      chk("rd_dout_e2", 32'(DATA_OUT),   32'hBEEF);
      chk("rd_rc_e2",   32'(READ_COUNT), 32'h1);

      // address change while driving
      ADDRESS = 18'h00006;
      #1 chk("chg_oe_now", 32'(DATA_OE), 32'h0);
      tick(); chk("chg_oe_f0", 32'(DATA_OE), 32'h0);
      tick(); chk("chg_oe_f1", 32'(DATA_OE), 32'h0);
      tick();
      chk("chg_oe_f2",   32'(DATA_OE),    32'h1);
      chk("chg_dout_f2", 32'(DATA_OUT),   32'h1234);
      chk("chg_rc_f2",   32'(READ_COUNT), 32'h2);
      tick();
      chk("hold_oe", 32'(DATA_OE),    32'h1);
      chk("hold_rc", 32'(READ_COUNT), 32'h2);

      // write during READ_WAIT
      ADDRESS = 18'h00005;
      tick();
      WEX = 1'b0; OEX = 1'b1; DATA_IN = 16'hAAAA;
      #1 chk("ww_oe_wait", 32'(DATA_OE), 32'h0);
      tick();
      chk("ww_wc", 32'(WRITE_COUNT), 32'h3);
      chk("ww_rc", 32'(READ_COUNT),  32'h2);
      WEX = 1'b1; OEX = 1'b0;
      tick(); chk("ww_oe_e0", 32'(DATA_OE), 32'h0);
      tick(); chk("ww_oe_e1", 32'(DATA_OE), 32'h0);
      tick();
      chk("ww_oe_e2",   32'(DATA_OE),    32'h1);
      chk("ww_dout_e2", 32'(DATA_OUT),   32'hAAAA);
      chk("ww_rc_e2",   32'(READ_COUNT), 32'h3);

      // conflict + alias of 0x01005 onto 0x00005
      chk("cf_pre", 32'(CONFLICT), 32'h0);
      WEX = 1'b0; OEX = 1'b0; ADDRESS = 18'h01005; DATA_IN = 16'h5A5A;
      tick();
      chk("cf_set", 32'(CONFLICT),    32'h1);
      chk("cf_wc",  32'(WRITE_COUNT), 32'h4);
      CSX = 1'b1; WEX = 1'b1; OEX = 1'b1;
      tick();
      chk("cf_sticky", 32'(CONFLICT), 32'h1);
      CSX = 1'b0; OEX = 1'b0; ADDRESS = 18'h00005;
      tick(); tick(); tick();
      chk("alias_oe",   32'(DATA_OE),    32'h1);
      chk("alias_dout", 32'(DATA_OUT),   32'h5A5A);
      chk("alias_rc",   32'(READ_COUNT), 32'h4);

      // asynchronous reset while driving
      #2 RST_N = 1'b0;
      #1;
      chk("ar_oe",   32'(DATA_OE),    32'h0);
      chk("ar_dout", 32'(DATA_OUT),   32'h0);
      chk("ar_rc",   32'(READ_COUNT), 32'h0);
      chk("ar_conf", 32'(CONFLICT),   32'h0);
      CSX = 1'b1; #2 RST_N = 1'b1;
      tick();

      // array survives reset
      CSX = 1'b0; WEX = 1'b1; OEX = 1'b0; ADDRESS = 18'h00006;
      tick(); tick(); tick();
      chk("keep_dout", 32'(DATA_OUT),   32'h1234);
      chk("keep_rc",   32'(READ_COUNT), 32'h1);

      // write counter saturation
      CSX = 1'b1;
      tick();
      force dut.r_wr_cnt = 16'hFFFE;
      #1 release dut.r_wr_cnt;
      chk("sat_pre", 32'(WRITE_COUNT), 32'hFFFE);
      CSX = 1'b0; WEX = 1'b0; OEX = 1'b1; ADDRESS = 18'h00007; DATA_IN = 16'h0001;
      tick(); chk("sat_w1", 32'(WRITE_COUNT), 32'hFFFF);
      tick();
      tick(); chk("sat_w3", 32'(WRITE_COUNT), 32'hFFFF);
      CSX = 1'b1; WEX = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
